// File: rtl/lab2_stim_check.sv
// Self-running stimulus/check stage for the two-input Lab 2 gate network.
// Sweeps {in1,in2} through 00..11, samples out1 after a settle window and scores it.
//
// state | meaning
// IDLE  | waiting for start, outputs cleared by reset
// RUN   | sweeping vectors, counting settle cycles, comparing samples
// DONE  | results held until the next start or rst
module lab2_stim_check #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned PASSES    = 1,
  parameter logic [3:0]  EXP_TABLE = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out1,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] PASSES_M1 = 8'(PASSES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] sweep;
  logic [1:0] vec;
  logic       out1_s;
  logic       mismatch;
  logic [7:0] err_next;

  // out1_s is captured one edge ahead of the compare, so the scored value is
  // out1 as it stood during cycle SETTLE-2 of the window.
  always_comb begin
    mismatch = (out1_s != EXP_TABLE[vec]);
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out1_s    <= 1'b0;
      cnt       <= 8'd0;
      sweep     <= 8'd0;
      vec       <= 2'd0;
      in1       <= 1'b0;
      in2       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_vec  <= 4'd0;
    end else begin
      out1_s <= out1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count <= 8'd0;
            fail_vec  <= 4'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            vec       <= 2'd0;
            sweep     <= 8'd0;
            in1       <= 1'b0;
            in2       <= 1'b0;
            cnt       <= SETTLE_M1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            err_count <= err_next;
            if (mismatch)
              fail_vec[vec] <= 1'b1;
            if (vec != 2'd3) begin
              vec        <= vec + 2'd1;
              {in1, in2} <= vec + 2'd1;
              cnt        <= SETTLE_M1;
            end else if (sweep != PASSES_M1) begin
              sweep      <= sweep + 8'd1;
              vec        <= 2'd0;
              {in1, in2} <= 2'b00;
              cnt        <= SETTLE_M1;
            end else begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_next == 8'd0);
              {in1, in2} <= 2'b00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
